// File: rtl/pp_buf_pkg.sv
// ---------------------------------------------------------------------------
// pp_buf_pkg
// Shared defaults for the ping-pong frame buffer and helpers that size the
// write pointer and the per-bank word index from DEPTH.
//   PP_DATA_W / PP_DEPTH / PP_ADDR_W : default stored-word width, words per
//                                      bank and read-address width.
//   pp_ptr_w(depth)                  : pointer width able to hold 0..depth.
//   pp_idx_w(depth)                  : index width for 0..depth-1 (min 1).
// ---------------------------------------------------------------------------
package pp_buf_pkg;

  localparam int unsigned PP_DATA_W = 8;
  localparam int unsigned PP_DEPTH  = 1024;
  localparam int unsigned PP_ADDR_W = 16;

  // The pointer must represent DEPTH itself (the "bank full" value).
  function automatic int unsigned pp_ptr_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned pp_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned PP_PTR_W = pp_ptr_w(PP_DEPTH);
  localparam int unsigned PP_IDX_W = pp_idx_w(PP_DEPTH);

endpackage

// File: rtl/pp_bank_ram.sv
// ---------------------------------------------------------------------------
// pp_bank_ram
// One bank of the ping-pong buffer: simple dual-port RAM with a synchronous
// write port and a synchronous, registered read port. Reads at addresses
// beyond the bank return zero. Only the read register is reset; the array
// keeps its contents across reset.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset (read register only)
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read address (full consumer address width)
//   rdata_o  : registered read data, one cycle after raddr_i
// ---------------------------------------------------------------------------
module pp_bank_ram
  import pp_buf_pkg::*;
#(
  parameter int unsigned DATA_W = PP_DATA_W,
  parameter int unsigned DEPTH  = PP_DEPTH,
  parameter int unsigned ADDR_W = PP_ADDR_W,
  localparam int unsigned IDX_W = pp_idx_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              raddr_ok;

  assign raddr_ok = ({1'b0, raddr_i} < DEPTH_EXT);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (raddr_ok) begin
      rdata_d = mem_q[raddr_i[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ping_pong_buffer.sv
// ---------------------------------------------------------------------------
// ping_pong_buffer
// Double-buffered byte store between a streaming producer and the
// convolution engine's random-access reader. The producer fills bank[sel]
// sequentially; the consumer reads bank[~sel] by address. A rising edge on
// the switch request swaps the roles and reports whether the bank being
// handed to the consumer was completely filled.
//   i_clk             : clock
//   i_rst             : asynchronous active-high reset
//   i_switch_pingpong : bank-swap request, acted on at its rising edge
//   i_data_din        : write data
//   i_data_din_vld    : write strobe, one word per cycle
//   i_conv_addr       : read address into the read bank
//   o_conv_dout       : read data, one cycle after i_conv_addr
//   o_pl_buffer_ready : read bank holds a complete frame
// ---------------------------------------------------------------------------
module ping_pong_buffer
  import pp_buf_pkg::*;
#(
  parameter int unsigned DATA_W = PP_DATA_W,
  parameter int unsigned DEPTH  = PP_DEPTH,
  parameter int unsigned ADDR_W = PP_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_switch_pingpong,
  input  logic [DATA_W-1:0] i_data_din,
  input  logic              i_data_din_vld,
  input  logic [ADDR_W-1:0] i_conv_addr,
  output logic [DATA_W-1:0] o_conv_dout,
  output logic              o_pl_buffer_ready
);

  localparam int unsigned      PTR_W    = pp_ptr_w(DEPTH);
  localparam int unsigned      IDX_W    = pp_idx_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  logic             sel_q;
  logic             sel_d;
  logic             sw_q;
  logic             ready_q;
  logic             ready_d;
  logic             rd_sel_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic             sw_edge;
  logic             wr_en;
  logic             we0;
  logic             we1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign sw_edge = i_switch_pingpong & ~sw_q;

  // Pointer saturates at DEPTH; writes beyond that are dropped.
  assign wr_en = i_data_din_vld & (wr_ptr_q < PTR_FULL);

  assign we0 = wr_en & ~sel_q;
  assign we1 = wr_en &  sel_q;

  always_comb begin
    wr_ptr_inc = wr_ptr_q + PTR_W'(wr_en);
    sel_d      = sel_q;
    wr_ptr_d   = wr_ptr_inc;
    ready_d    = ready_q;
    if (sw_edge) begin
      sel_d    = ~sel_q;
      wr_ptr_d = '0;
      // A write on the swap cycle still lands in the outgoing bank and
      // counts toward its fullness.
      ready_d  = (wr_ptr_inc == PTR_FULL);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q    <= 1'b0;
      wr_ptr_q <= '0;
      sw_q     <= 1'b0;
      ready_q  <= 1'b0;
      rd_sel_q <= 1'b1;
    end else begin
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      sw_q     <= i_switch_pingpong;
      ready_q  <= ready_d;
      // Remembers which bank the RAM read registers were loaded from, so
      // the swap cycle's read still comes from the pre-swap read bank.
      rd_sel_q <= ~sel_q;
    end
  end

  pp_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .we_i    (we0),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i (i_data_din),
    .raddr_i (i_conv_addr),
    .rdata_o (rdata0)
  );

  pp_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .we_i    (we1),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i (i_data_din),
    .raddr_i (i_conv_addr),
    .rdata_o (rdata1)
  );

  // Both selects are registers and both RAM outputs are registers.
  assign o_conv_dout       = rd_sel_q ? rdata1 : rdata0;
  assign o_pl_buffer_ready = ready_q;

endmodule

// File: tb/tb_ping_pong_buffer.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_buffer
// Randomized and directed stimulus for ping_pong_buffer, checked every cycle
// against a behavioural model: two word arrays, a write count, the current
// write bank, a ready bit and the previous switch level.
// ---------------------------------------------------------------------------
module tb_ping_pong_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              sw;
  logic [DATA_W-1:0] din;
  logic              vld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              ready;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model
  logic [DATA_W-1:0] m_mem   [2][DEPTH];
  bit                m_known [2][DEPTH];
  int                m_sel;
  int                m_cnt;
  bit                m_ready;
  bit                m_sw_prev;

  ping_pong_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_switch_pingpong (sw),
    .i_data_din        (din),
    .i_data_din_vld    (vld),
    .i_conv_addr       (addr),
    .o_conv_dout       (dout),
    .o_pl_buffer_ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel     = 0;
    m_cnt     = 0;
    m_ready   = 0;
    m_sw_prev = 0;
  endtask

  // Advance one clock with the inputs currently driven, then check outputs.
  task automatic step();
    bit                edge_now;
    bit                exp_known;
    logic [DATA_W-1:0] exp_dout;
    int                a;
    int                rb;
    edge_now = sw && !m_sw_prev;
    rb       = 1 - m_sel;
    a        = int'(addr);
    if (a >= DEPTH) begin
      exp_dout  = '0;
      exp_known = 1;
    end else begin
      exp_dout  = m_mem[rb][a];
      exp_known = m_known[rb][a];
    end
    if (vld && m_cnt < DEPTH) begin
      m_mem[m_sel][m_cnt]   = din;
      m_known[m_sel][m_cnt] = 1;
      m_cnt++;
    end
    if (edge_now) begin
      m_ready = (m_cnt == DEPTH);
      m_sel   = 1 - m_sel;
      m_cnt   = 0;
    end
    m_sw_prev = sw;
    @(posedge clk);
    #1;
    if (exp_known) chk("dout", dout, exp_dout);
    chk("ready", ready, m_ready);
  endtask

  task automatic rand_addr();
    addr = ADDR_W'($urandom_range(0, DEPTH + 8));
  endtask

  task automatic fill_const(input int n, input logic [DATA_W-1:0] val);
    for (int i = 0; i < n; i++) begin
      vld = 1;
      din = val;
      rand_addr();
      step();
    end
    vld = 0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      vld = 1;
      din = DATA_W'($urandom);
      rand_addr();
      step();
    end
    vld = 0;
  endtask

  task automatic do_swap();
    vld = 0;
    sw  = 1;
    step();
    sw  = 0;
    step();
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic async_reset();
    #2;
    rst = 1;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_ready", ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst  = 1;
    sw   = 0;
    din  = '0;
    vld  = 0;
    addr = '0;
    model_reset();
    #2;
    chk("por_dout", dout, 0);
    chk("por_ready", ready, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      rand_addr();
      step();
      chk("idle_dout", dout, 0);
      chk("idle_ready", ready, 0);
    end

    // full fill with overflow, held switch request
    fill_const(1200, 8'd8);
    sw = 1;
    for (int i = 0; i < 4; i++) begin
      rand_addr();
      step();
    end
    chk("full_ready", ready, 1);
    addr = 16'd0;    step(); chk("full_a0", dout, 8);
    addr = 16'd500;  step(); chk("full_a500", dout, 8);
    addr = 16'd1023; step(); chk("full_a1023", dout, 8);
    addr = 16'd1024; step(); chk("full_a1024", dout, 0);
    sw = 0;
    step();

    // partial fill
    for (int i = 0; i < 10; i++) begin
      vld = 1;
      din = DATA_W'(8'h10 + i);
      step();
    end
    vld = 0;
    do_swap();
    chk("part_ready", ready, 0);
    addr = 16'd3;
    step();
    chk("part_a3", dout, 8'h13);

    // ping-pong alternation
    fill_const(DEPTH, 8'hAA);
    do_swap();
    chk("pp_ready1", ready, 1);
    fill_const(DEPTH, 8'h55);
    addr = 16'd7;
    step();
    chk("pp_aa", dout, 8'hAA);
    do_swap();
    chk("pp_ready2", ready, 1);
    for (int i = 0; i < 8; i++) begin
      addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
      chk("pp_55", dout, 8'h55);
    end

    // last word written on the swap cycle
    fill_rand(DEPTH - 1);
    vld = 1;
    din = DATA_W'($urandom);
    sw  = 1;
    step();
    chk("sim_ready", ready, 1);
    din = 8'h5A;
    step();
    vld = 0;
    sw  = 0;
    step();
    do_swap();
    chk("sim_ready2", ready, 0);
    addr = 16'd0;
    step();
    chk("sim_new_a0", dout, 8'h5A);

    // async reset mid-fill
    fill_rand(DEPTH);
    do_swap();
    chk("pre_rst_ready", ready, 1);
    fill_rand(300);
    async_reset();
    for (int i = 0; i < 3; i++) begin
      rand_addr();
      step();
      chk("post_rst_ready", ready, 0);
    end
    fill_rand(DEPTH);
    do_swap();
    chk("refill_ready", ready, 1);
    for (int i = 0; i < 40; i++) begin
      a    = $urandom_range(0, DEPTH - 1);
      addr = ADDR_W'(a);
      step();
      chk("refill_data", dout, m_mem[1 - m_sel][a]);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      din = DATA_W'($urandom);
      if ($urandom_range(0, 399) == 0) sw = ~sw;
      rand_addr();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
